// File: rtl/cpu_mmio_pkg.sv
// cpu_mmio_pkg: shared constants and types for the MMIO console peripheral
package cpu_mmio_pkg;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h0002_0000;

    localparam logic [3:0] OFS_TXDATA = 4'h0;
    localparam logic [3:0] OFS_TEST   = 4'h4;
    localparam logic [3:0] OFS_STATUS = 4'h8;

    localparam int STATUS_FULL = 0;
    localparam int STATUS_BUSY = 1;
    localparam int STATUS_OVF  = 2;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; a push into a full FIFO is taken only when a pop frees a slot that cycle
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // occupancy never exceeds DEPTH because a full push needs a simultaneous pop
    always_comb begin
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // storage is not reset; only the pointers define valid contents
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    // pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mmio_console.sv
// mmio_console: memory-mapped UART console and test-result latch on the cpu data port
module mmio_console
    import cpu_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = BASE_ADDR_DEFAULT,
    parameter int          CLKS_PER_BIT = 4,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        sel,
    output logic        uart_tx,
    output logic        done,
    output logic        pass,
    output logic [31:0] fail_code
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    logic [3:0]    ofs;
    logic          wr_tx, wr_test, wr_status;
    logic          fifo_pop, fifo_full, fifo_empty, tx_busy, baud_end;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    tx_state_e     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          ovf_q, ovf_d, done_q, pass_q;
    logic [31:0]   fail_q, rdata_q, rdata_d, status;

    assign sel       = mem_addr[31:4] == BASE_ADDR[31:4];
    assign ofs       = mem_addr[3:0];
    assign wr_tx     = mem_write & sel & (ofs == OFS_TXDATA);
    assign wr_test   = mem_write & sel & (ofs == OFS_TEST);
    assign wr_status = mem_write & sel & (ofs == OFS_STATUS);
    assign tx_busy   = (state_q != IDLE) | ~fifo_empty;
    assign baud_end  = baud_q == BW'(CLKS_PER_BIT - 1);
    assign mem_rdata = rdata_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_code = fail_q;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (wr_tx),
        .din_i   (mem_wdata[7:0]),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // TX framing: the baud counter is held at zero in IDLE so every bit lasts exactly CLKS_PER_BIT
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_end ? '0 : baud_q + BW'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        uart_tx  = 1'b1;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    state_d  = START;
                end
            end
            START: begin
                uart_tx = 1'b0;
                if (baud_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                uart_tx = shift_q[0];
                if (baud_end) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    state_d = bit_q == 3'd7 ? STOP : DATA;
                end
            end
            STOP: state_d = baud_end ? IDLE : STOP;
            default: state_d = IDLE;
        endcase
    end

    // register read mux and sticky overflow; a dropped byte is a full push with no pop to make room
    always_comb begin
        status              = '0;
        status[STATUS_OVF]  = ovf_q;
        status[STATUS_BUSY] = tx_busy;
        status[STATUS_FULL] = fifo_full;
        ovf_d   = wr_status ? 1'b0 : ovf_q | (wr_tx & fifo_full & ~fifo_pop);
        rdata_d = !(sel && !mem_write) ? '0 :
                  ofs == OFS_TXDATA    ? 32'(fifo_count) :
                  ofs == OFS_TEST      ? {31'b0, done_q} :
                  ofs == OFS_STATUS    ? status : '0;
    end

    // state registers; the first result written wins until the next reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ovf_q   <= ovf_d;
            rdata_q <= rdata_d;
            if (wr_test && !done_q) begin
                done_q <= 1'b1;
                pass_q <= mem_wdata == 32'd0;
                fail_q <= mem_wdata;
            end
        end
    end

endmodule

// File: tb/tb_mmio_console.sv
// tb_mmio_console: register-map vectors, UART frame scoreboard and reset/overflow sequences
module tb_mmio_console;

    localparam int          CPB  = 4;
    localparam logic [31:0] BASE = 32'h0002_0000;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_sel;
        logic [31:0] exp_rdata;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_write = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata, fail_code;
    logic        sel, uart_tx, done, pass;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic        mon_abort;
    vec_t        vt[12];

    mmio_console #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .sel       (sel),
        .uart_tx   (uart_tx),
        .done      (done),
        .pass      (pass),
        .fail_code (fail_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus(input logic we, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_write = we;
        mem_addr  = a;
        mem_wdata = d;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus(1'b1, a, d);
        bus(1'b0, '0, '0);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus(1'b0, a, '0);
        @(negedge clk);
        d = mem_rdata;
        mem_addr = '0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        mem_write = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic mon_wait(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (reset) mon_abort = 1'b1;
        end
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // UART receiver: start detected half a clock in, each bit sampled near its centre
    initial begin
        logic [7:0] b;
        logic       stop;
        forever begin
            @(negedge clk);
            if (!reset && uart_tx === 1'b0) begin
                mon_abort = 1'b0;
                mon_wait(CPB + CPB / 2);
                b[0] = uart_tx;
                for (int i = 1; i < 8; i++) begin
                    mon_wait(CPB);
                    b[i] = uart_tx;
                end
                mon_wait(CPB);
                stop = uart_tx;
                if (!mon_abort) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL uart_unexpected: got byte %h expected no frame", b);
                    end else begin
                        check("uart_byte", 64'(b), 64'(exp_q.pop_front()));
                        check("uart_stop", 64'(stop), 64'd1);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] r;
        logic        saw_low, saw_rd, saw_done;
        logic [63:0] cap, expw;
        logic [7:0]  byte_v;
        int          s;

        vt[0]  = '{1'b0, BASE + 32'h0, 32'h0,  1'b1, 32'h0, "rd_txdata"};
        vt[1]  = '{1'b0, BASE + 32'h4, 32'h0,  1'b1, 32'h0, "rd_test"};
        vt[2]  = '{1'b0, BASE + 32'h8, 32'h0,  1'b1, 32'h0, "rd_status"};
        vt[3]  = '{1'b0, BASE + 32'hC, 32'h0,  1'b1, 32'h0, "rd_unmapped"};
        vt[4]  = '{1'b0, BASE + 32'h10, 32'h0, 1'b0, 32'h0, "rd_next_block"};
        vt[5]  = '{1'b0, BASE - 32'h8, 32'h0,  1'b0, 32'h0, "rd_below"};
        vt[6]  = '{1'b1, BASE + 32'h10, 32'h55, 1'b0, 32'h0, "wr_next_block"};
        vt[7]  = '{1'b1, BASE + 32'h14, 32'h0, 1'b0, 32'h0, "wr_next_test"};
        vt[8]  = '{1'b1, BASE + 32'hC, 32'h0,  1'b1, 32'h0, "wr_unmapped"};
        vt[9]  = '{1'b0, BASE + 32'h4, 32'h0,  1'b1, 32'h0, "rd_test_still0"};
        vt[10] = '{1'b1, BASE + 32'h4, 32'h0,  1'b1, 32'h0, "wr_test_pass"};
        vt[11] = '{1'b0, BASE + 32'h4, 32'h0,  1'b1, 32'h1, "rd_test_done"};

        do_reset();
        saw_low = 1'b0;
        saw_rd = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            saw_low  |= uart_tx !== 1'b1;
            saw_rd   |= mem_rdata !== 32'h0;
            saw_done |= done !== 1'b0;
        end
        check("idle_uart_low", 64'(saw_low), 64'd0);
        check("idle_rdata", 64'(saw_rd), 64'd0);
        check("idle_done", 64'(saw_done), 64'd0);
        rd(BASE + 32'h8, r);
        check("status_reset", 64'(r), 64'd0);

        for (int i = 0; i < 12; i++) begin
            bus(vt[i].we, vt[i].addr, vt[i].wdata);
            #1;
            check({vt[i].name, "_sel"}, 64'(sel), 64'(vt[i].exp_sel));
            @(negedge clk);
            check({vt[i].name, "_rdata"}, 64'(mem_rdata), 64'(vt[i].exp_rdata));
            mem_write = 1'b0;
        end
        check("pass_first", {31'b0, done, pass, fail_code}, {31'b0, 1'b1, 1'b1, 32'h0});
        wr(BASE + 32'h4, 32'h5);
        @(negedge clk);
        check("second_result_ignored", {31'b0, done, pass, fail_code}, {31'b0, 1'b1, 1'b1, 32'h0});
        do_reset();
        check("result_reset", {31'b0, done, pass, fail_code}, 64'd0);
        wr(BASE + 32'h4, 32'h7);
        @(negedge clk);
        check("fail_result", {31'b0, done, pass, fail_code}, {31'b0, 1'b1, 1'b0, 32'h7});

        do_reset();
        byte_v = 8'h41;
        exp_q.push_back(byte_v);
        bus(1'b1, BASE, 32'h41);
        bus(1'b0, '0, '0);
        cap = '0;
        cap[0] = uart_tx;
        for (int k = 1; k < 42; k++) begin
            @(negedge clk);
            cap[k] = uart_tx;
        end
        expw = '0;
        expw[0] = 1'b1;
        for (int k = 1; k < 42; k++) begin
            s = (k - 1) / CPB;
            expw[k] = s == 0 ? 1'b0 : s <= 8 ? byte_v[s-1] : 1'b1;
        end
        check("frame_0x41_wave", cap, expw);
        drain("drain_single", 100);

        for (int i = 0; i < 10; i++) begin
            bus(1'b1, BASE, 32'h10 + 32'(i));
            if (i < 9) exp_q.push_back(8'(8'h10 + i));
        end
        bus(1'b0, '0, '0);
        rd(BASE + 32'h8, r);
        check("status_overflow", 64'(r), 64'h7);
        rd(BASE, r);
        check("count_full", 64'(r), 64'h8);
        wr(BASE + 32'h8, 32'h0);
        rd(BASE + 32'h8, r);
        check("status_ovf_cleared", 64'(r), 64'h3);
        drain("drain_burst", 9 * 41 + 60);
        repeat (5) @(negedge clk);
        rd(BASE, r);
        check("count_empty", 64'(r), 64'h0);
        rd(BASE + 32'h8, r);
        check("status_idle", 64'(r), 64'h0);

        do_reset();
        for (int i = 0; i < 4; i++) bus(1'b1, BASE, 32'hA0 + 32'(i));
        bus(1'b0, '0, '0);
        rd(BASE, r);
        check("count_queued", 64'(r), 64'h3);
        repeat (13) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_tx_high", 64'(uart_tx), 64'd1);
        reset = 1'b0;
        rd(BASE, r);
        check("abort_count", 64'(r), 64'h0);
        saw_low = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            saw_low |= uart_tx !== 1'b1;
        end
        check("no_frames_after_abort", 64'(saw_low), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
